// File: rtl/parc_rob_pkg.sv
// Shared types and sizing helpers for the pv2ooo reorder buffer.
// The destination register lives in a separate array because its width is a top-level parameter.
package parc_rob_pkg;

  localparam int DEFAULT_DEPTH    = 16;
  localparam int DEFAULT_PREG_W   = 5;
  localparam int DEFAULT_NUM_FILL = 2;

  typedef struct packed {
    logic valid;
    logic pending;
    logic wen;
    logic mispred;
  } rob_entry_t;

  function automatic int slot_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/parc_rob_fill_decode.sv
// Folds the writeback ports into per-slot clear-pending / set-mispred masks.
// Masks are ORed across ports, so duplicate fills to one slot in a cycle merge naturally.
module parc_rob_fill_decode
  import parc_rob_pkg::*;
#(
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int NUM_FILL = DEFAULT_NUM_FILL,
  localparam int SLOT_W   = slot_w(DEPTH)
) (
  input  logic [NUM_FILL-1:0]        fill_val,
  input  logic [NUM_FILL*SLOT_W-1:0] fill_slot,
  input  logic [NUM_FILL-1:0]        fill_mispred,
  output logic [DEPTH-1:0]           clear_pending,
  output logic [DEPTH-1:0]           set_mispred
);

  logic hit_s;

  // Per-slot OR of every port that names this slot.
  always_comb begin
    clear_pending = '0;
    set_mispred   = '0;
    hit_s         = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      for (int p = 0; p < NUM_FILL; p++) begin
        hit_s            = fill_val[p] && (fill_slot[p*SLOT_W +: SLOT_W] == SLOT_W'(s));
        clear_pending[s] = clear_pending[s] | hit_s;
        set_mispred[s]   = set_mispred[s] | (hit_s & fill_mispred[p]);
      end
    end
  end

endmodule

// File: rtl/parc_core_rob_multi.sv
// In-order-retire reorder buffer with NUM_FILL writeback ports and
// flush-on-mispredict at commit.
module parc_core_rob_multi
  import parc_rob_pkg::*;
#(
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int PREG_W   = DEFAULT_PREG_W,
  parameter  int NUM_FILL = DEFAULT_NUM_FILL,
  localparam int SLOT_W   = slot_w(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_req_val,
  output logic                       alloc_req_rdy,
  input  logic [PREG_W-1:0]          alloc_req_preg,
  input  logic                       alloc_req_wen,
  output logic [SLOT_W-1:0]          alloc_resp_slot,
  input  logic [NUM_FILL-1:0]        fill_val,
  input  logic [NUM_FILL*SLOT_W-1:0] fill_slot,
  input  logic [NUM_FILL-1:0]        fill_mispred,
  output logic                       commit_val,
  output logic [SLOT_W-1:0]          commit_slot,
  output logic                       commit_rf_wen,
  output logic [PREG_W-1:0]          commit_rf_waddr,
  output logic                       commit_flush,
  output logic [SLOT_W:0]            rob_count,
  output logic                       rob_empty
);

  localparam int              CNT_W     = SLOT_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [SLOT_W-1:0] SLOT_ONE = SLOT_W'(1);

  rob_entry_t         entries_r [DEPTH];
  logic [PREG_W-1:0]  preg_r    [DEPTH];
  logic [SLOT_W-1:0]  head_r;
  logic [SLOT_W-1:0]  tail_r;
  logic [CNT_W-1:0]   count_r;

  logic [DEPTH-1:0]   clear_pending_s;
  logic [DEPTH-1:0]   set_mispred_s;
  logic [DEPTH-1:0]   fill_hit_s;
  logic               alloc_fire_s;

  parc_rob_fill_decode #(
    .DEPTH    (DEPTH),
    .NUM_FILL (NUM_FILL)
  ) u_fill_decode (
    .fill_val      (fill_val),
    .fill_slot     (fill_slot),
    .fill_mispred  (fill_mispred),
    .clear_pending (clear_pending_s),
    .set_mispred   (set_mispred_s)
  );

  // Stale or duplicate fills (entry not live or already complete) are dropped here.
  always_comb begin
    fill_hit_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fill_hit_s[i] = clear_pending_s[i] & entries_r[i].valid & entries_r[i].pending;
    end
  end

  assign commit_val      = entries_r[head_r].valid && !entries_r[head_r].pending;
  assign commit_flush    = commit_val && entries_r[head_r].mispred;
  assign commit_slot     = head_r;
  assign commit_rf_wen   = commit_val && entries_r[head_r].wen;
  assign commit_rf_waddr = preg_r[head_r];

  // Full is judged on count, and a retiring slot is not handed out in the same cycle.
  assign alloc_req_rdy   = (count_r < DEPTH_CNT) && !commit_flush;
  assign alloc_fire_s    = alloc_req_val && alloc_req_rdy;
  assign alloc_resp_slot = tail_r;
  assign rob_count       = count_r;
  assign rob_empty       = (count_r == {CNT_W{1'b0}});

  // Entry status, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {SLOT_W{1'b0}};
      tail_r  <= {SLOT_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
    end else if (commit_flush) begin
      // The mispredicted branch retires; everything younger is squashed.
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
      head_r  <= head_r + SLOT_ONE;
      tail_r  <= head_r + SLOT_ONE;
      count_r <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fill_hit_s[i]) begin
          entries_r[i].pending <= 1'b0;
          entries_r[i].mispred <= entries_r[i].mispred | set_mispred_s[i];
        end
      end
      if (commit_val) begin
        entries_r[head_r].valid <= 1'b0;
        head_r                  <= head_r + SLOT_ONE;
      end
      if (alloc_fire_s) begin
        entries_r[tail_r].valid   <= 1'b1;
        entries_r[tail_r].pending <= 1'b1;
        entries_r[tail_r].wen     <= alloc_req_wen;
        entries_r[tail_r].mispred <= 1'b0;
        tail_r                    <= tail_r + SLOT_ONE;
      end
      count_r <= count_r + CNT_W'(alloc_fire_s) - CNT_W'(commit_val);
    end
  end

  // Destination register payload; only meaningful while the entry is valid.
  always_ff @(posedge clk) begin
    if (!reset && alloc_fire_s) begin
      preg_r[tail_r] <= alloc_req_preg;
    end
  end

endmodule

// File: tb/tb_parc_core_rob_multi.sv
// Directed self-checking bench for parc_core_rob_multi (DEPTH=16, PREG_W=5, NUM_FILL=2).
module tb_parc_core_rob_multi;

  localparam int DEPTH  = 16;
  localparam int PREG_W = 5;
  localparam int NF     = 2;
  localparam int SW     = 4;

  logic              clk;
  logic              reset;
  logic              alloc_req_val;
  logic              alloc_req_rdy;
  logic [PREG_W-1:0] alloc_req_preg;
  logic              alloc_req_wen;
  logic [SW-1:0]     alloc_resp_slot;
  logic [NF-1:0]     fill_val;
  logic [NF*SW-1:0]  fill_slot;
  logic [NF-1:0]     fill_mispred;
  logic              commit_val;
  logic [SW-1:0]     commit_slot;
  logic              commit_rf_wen;
  logic [PREG_W-1:0] commit_rf_waddr;
  logic              commit_flush;
  logic [SW:0]       rob_count;
  logic              rob_empty;

  int n_checks = 0;
  int n_errors = 0;

  parc_core_rob_multi #(.DEPTH(DEPTH), .PREG_W(PREG_W), .NUM_FILL(NF)) dut (
    .clk             (clk),
    .reset           (reset),
    .alloc_req_val   (alloc_req_val),
    .alloc_req_rdy   (alloc_req_rdy),
    .alloc_req_preg  (alloc_req_preg),
    .alloc_req_wen   (alloc_req_wen),
    .alloc_resp_slot (alloc_resp_slot),
    .fill_val        (fill_val),
    .fill_slot       (fill_slot),
    .fill_mispred    (fill_mispred),
    .commit_val      (commit_val),
    .commit_slot     (commit_slot),
    .commit_rf_wen   (commit_rf_wen),
    .commit_rf_waddr (commit_rf_waddr),
    .commit_flush    (commit_flush),
    .rob_count       (rob_count),
    .rob_empty       (rob_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req_val  = 1'b0;
    alloc_req_preg = '0;
    alloc_req_wen  = 1'b0;
    fill_val       = '0;
    fill_slot      = '0;
    fill_mispred   = '0;
  endtask

  task automatic alloc(input int preg, input logic wen);
    alloc_req_val  = 1'b1;
    alloc_req_preg = PREG_W'(preg);
    alloc_req_wen  = wen;
  endtask

  task automatic fill(input int port, input int slot, input logic mp);
    fill_val[port]           = 1'b1;
    fill_slot[port*SW +: SW] = SW'(slot);
    fill_mispred[port]       = mp;
  endtask

  // Reset with junk alloc/fill requests asserted; they must be ignored.
  task automatic do_reset();
    alloc(1, 1'b1);
    fill(0, 0, 1'b1);
    fill(1, 1, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_rdy", 32'(alloc_req_rdy), 32'd1);
    check("rst_slot", 32'(alloc_resp_slot), 32'd0);
    check("rst_cval", 32'(commit_val), 32'd0);
    check("rst_rfwen", 32'(commit_rf_wen), 32'd0);
    check("rst_flush", 32'(commit_flush), 32'd0);
    check("rst_count", 32'(rob_count), 32'd0);
    check("rst_empty", 32'(rob_empty), 32'd1);

    // Fill to full with no completions.
    for (int i = 0; i < 16; i++) begin
      alloc(i, 1'b1);
      #1;
      check("full_slot", 32'(alloc_resp_slot), 32'(i));
      check("full_rdy", 32'(alloc_req_rdy), 32'd1);
      check("full_cval", 32'(commit_val), 32'd0);
      step();
    end
    check("full_rdy17", 32'(alloc_req_rdy), 32'd0);
    check("full_count", 32'(rob_count), 32'd16);
    check("full_empty", 32'(rob_empty), 32'd0);
    step();
    check("full_hold", 32'(rob_count), 32'd16);
    check("full_nocommit", 32'(commit_val), 32'd0);

    // Mid-operation reset discards everything.
    do_reset();
    check("mrst_count", 32'(rob_count), 32'd0);
    check("mrst_slot", 32'(alloc_resp_slot), 32'd0);
    check("mrst_cval", 32'(commit_val), 32'd0);

    // Out-of-order fills, in-order commits.
    alloc(5, 1'b1); step();
    alloc(6, 1'b0); step();
    alloc(7, 1'b1); step();
    idle();
    fill(0, 2, 1'b0); #1;
    check("ooo_c0", 32'(commit_val), 32'd0);
    step();
    idle();
    fill(0, 0, 1'b0); #1;
    check("ooo_c1", 32'(commit_val), 32'd0);
    step();
    idle();
    fill(1, 1, 1'b0); #1;
    check("ooo_s0_val", 32'(commit_val), 32'd1);
    check("ooo_s0_slot", 32'(commit_slot), 32'd0);
    check("ooo_s0_wen", 32'(commit_rf_wen), 32'd1);
    check("ooo_s0_addr", 32'(commit_rf_waddr), 32'd5);
    check("ooo_s0_flush", 32'(commit_flush), 32'd0);
    step();
    idle(); #1;
    check("ooo_s1_val", 32'(commit_val), 32'd1);
    check("ooo_s1_slot", 32'(commit_slot), 32'd1);
    check("ooo_s1_wen", 32'(commit_rf_wen), 32'd0);
    step();
    check("ooo_s2_val", 32'(commit_val), 32'd1);
    check("ooo_s2_slot", 32'(commit_slot), 32'd2);
    check("ooo_s2_addr", 32'(commit_rf_waddr), 32'd7);
    check("ooo_s2_wen", 32'(commit_rf_wen), 32'd1);
    step();
    check("ooo_done", 32'(commit_val), 32'd0);
    check("ooo_empty", 32'(rob_empty), 32'd1);

    // Both ports fill the same slot; mispred is ORed.
    do_reset();
    alloc(3, 1'b1); step();
    idle();
    fill(0, 0, 1'b0);
    fill(1, 0, 1'b1); #1;
    check("dup_c0", 32'(commit_val), 32'd0);
    step();
    idle();
    alloc(4, 1'b1); #1;
    check("dup_val", 32'(commit_val), 32'd1);
    check("dup_flush", 32'(commit_flush), 32'd1);
    check("dup_rdy", 32'(alloc_req_rdy), 32'd0);
    check("dup_wen", 32'(commit_rf_wen), 32'd1);
    check("dup_addr", 32'(commit_rf_waddr), 32'd3);
    step();
    idle(); #1;
    check("dup_count", 32'(rob_count), 32'd0);
    check("dup_after", 32'(commit_val), 32'd0);
    check("dup_tail", 32'(alloc_resp_slot), 32'd1);

    // Flush squashes younger entries.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      alloc(10 + i, 1'b1);
      step();
    end
    idle();
    fill(0, 1, 1'b1);
    fill(1, 0, 1'b0);
    step();
    idle();
    fill(0, 2, 1'b0);
    fill(1, 3, 1'b0); #1;
    check("fl_s0_val", 32'(commit_val), 32'd1);
    check("fl_s0_slot", 32'(commit_slot), 32'd0);
    check("fl_s0_flush", 32'(commit_flush), 32'd0);
    step();
    idle();
    alloc(20, 1'b1); #1;
    check("fl_s1_val", 32'(commit_val), 32'd1);
    check("fl_s1_slot", 32'(commit_slot), 32'd1);
    check("fl_s1_flush", 32'(commit_flush), 32'd1);
    check("fl_s1_rdy", 32'(alloc_req_rdy), 32'd0);
    check("fl_s1_count", 32'(rob_count), 32'd5);
    step();
    idle(); #1;
    check("fl_count", 32'(rob_count), 32'd0);
    check("fl_tail", 32'(alloc_resp_slot), 32'd2);
    check("fl_empty", 32'(rob_empty), 32'd1);
    fill(0, 2, 1'b0);
    fill(1, 3, 1'b0);
    step();
    check("fl_ign0", 32'(commit_val), 32'd0);
    idle();
    fill(0, 4, 1'b0);
    fill(1, 5, 1'b0);
    step();
    check("fl_ign1", 32'(commit_val), 32'd0);
    check("fl_ign_count", 32'(rob_count), 32'd0);
    idle();
    alloc(9, 1'b1); #1;
    check("fl_new_slot", 32'(alloc_resp_slot), 32'd2);
    step();
    idle(); #1;
    check("fl_new_count", 32'(rob_count), 32'd1);
    check("fl_new_pend", 32'(commit_val), 32'd0);

    // Steady stream across the pointer wrap.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc(i, 1'b1);
      step();
    end
    for (int k = 0; k < 40; k++) begin
      idle();
      alloc((4 + k) % 16, 1'b1);
      fill(0, k % 16, 1'b0); #1;
      check("wr_slot", 32'(alloc_resp_slot), 32'((4 + k) % 16));
      check("wr_rdy", 32'(alloc_req_rdy), 32'd1);
      check("wr_count", 32'(rob_count), (k == 0) ? 32'd4 : 32'd5);
      check("wr_cval", 32'(commit_val), (k == 0) ? 32'd0 : 32'd1);
      if (k > 0) begin
        check("wr_cslot", 32'(commit_slot), 32'((k - 1) % 16));
        check("wr_addr", 32'(commit_rf_waddr), 32'((k - 1) % 16));
      end
      step();
    end

    // Full ROB with a ready head: commit fires, alloc waits one cycle.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc(i, 1'b0);
      step();
    end
    idle();
    fill(0, 0, 1'b0);
    step();
    idle();
    alloc(20, 1'b1); #1;
    check("fb_cval", 32'(commit_val), 32'd1);
    check("fb_rdy", 32'(alloc_req_rdy), 32'd0);
    check("fb_count", 32'(rob_count), 32'd16);
    step();
    check("fb_count1", 32'(rob_count), 32'd15);
    check("fb_rdy1", 32'(alloc_req_rdy), 32'd1);
    check("fb_slot1", 32'(alloc_resp_slot), 32'd0);
    check("fb_cval1", 32'(commit_val), 32'd0);
    step();
    idle(); #1;
    check("fb_count2", 32'(rob_count), 32'd16);
    check("fb_rdy2", 32'(alloc_req_rdy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
